rfft_out_fmt: RTL and testbench

Parametrised range-FFT output formatter between the FFT core master stream and the range-data consumers (corner turn / DDR writer). It scales each complex component by a frame-latched right shift with optional rounding and signed saturation, across NCH parallel channels. It regenerates sop/eop and a bin index from a frame-length counter and supports full valid/ready backpressure. It also reports saturation and frame-length mismatches.

---
 rtl/rfft_out_fmt_if.sv | 15 +
 rtl/rfft_out_fmt.sv | 156 +++++++++++++++
 tb/tb_rfft_out_fmt.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rfft_out_fmt_if.sv
// Stream bundle for the range-FFT formatter: the input side uses valid/ready/data/last,
// the output side additionally carries the sop flag and range bin index (last acts as eop).
interface rfft_out_fmt_if #(
  parameter int DW = 64
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;
  logic          sop;
  logic [15:0]   bin;

  modport master (output valid, data, last, sop, bin, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/rfft_out_fmt.sv
// Range-FFT output formatter: frame-latched shift/round/saturate over NCH complex lanes,
// regenerated sop/eop/bin framing, two-stage elastic pipeline, saturation and length checks.
module rfft_out_fmt #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int NCH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            i_cfg_shift,
  input  logic                  i_cfg_round,
  input  logic [15:0]           i_cfg_len,
  input  logic                  i_cfg_update,
  rfft_out_fmt_if.slave         s_if,
  rfft_out_fmt_if.master        m_if,
  input  logic                  i_sat_clr,
  output logic [31:0]           o_sat_cnt,
  output logic                  o_len_err
);
  localparam int NC    = 2 * NCH;
  localparam int SHMAX = IN_W - 1;
  localparam logic signed [IN_W:0] SAT_HI = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_LO = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [IN_W:0]        ONE    = {{IN_W{1'b0}}, 1'b1};

  logic                  r_pend;
  logic [4:0]            r_shift;
  logic                  r_round;
  logic [15:0]           r_len;
  logic [15:0]           r_bin_cnt;
  logic                  r_len_err;
  logic [31:0]           r_sat_cnt;

  logic                  r_s1_valid, r_s1_sop, r_s1_eop;
  logic [15:0]           r_s1_bin;
  logic                  r_s2_valid, r_s2_sop, r_s2_eop, r_s2_sat;
  logic [15:0]           r_s2_bin;
  logic [NC*OUT_W-1:0]   r_s2_data;

  logic                  w_s1_en, w_s2_en, w_accept, w_load, w_at_last, w_eop;
  logic [4:0]            w_live_shift, w_shift;
  logic                  w_round;
  logic [15:0]           w_len, w_last_idx;
  logic [IN_W:0]         w_rnd;
  logic [NC*OUT_W-1:0]   w_sat_data;
  logic [NC-1:0]         w_sat_vec;

  assign w_s2_en    = !r_s2_valid || m_if.ready;
  assign w_s1_en    = !r_s1_valid || w_s2_en;
  assign s_if.ready = w_s1_en;
  assign w_accept   = s_if.valid && w_s1_en;

  // The first beat of a frame both loads the shadow set and is processed with it.
  assign w_load       = w_accept && r_pend && (r_bin_cnt == 16'd0);
  assign w_live_shift = (int'(i_cfg_shift) > SHMAX) ? 5'(SHMAX) : i_cfg_shift;
  assign w_shift      = w_load ? w_live_shift : r_shift;
  assign w_round      = w_load ? i_cfg_round  : r_round;
  assign w_len        = w_load ? i_cfg_len    : r_len;
  // len = 0 wraps to index 0xFFFF, giving a 65536-point frame.
  assign w_last_idx   = w_len - 16'd1;
  assign w_at_last    = (r_bin_cnt == w_last_idx);
  assign w_eop        = w_at_last || s_if.last;
  assign w_rnd        = (w_round && (w_shift != 5'd0)) ? (ONE << (w_shift - 5'd1)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= 1'b0;
      r_shift   <= 5'd8;
      r_round   <= 1'b0;
      r_len     <= 16'd256;
      r_bin_cnt <= 16'd0;
      r_len_err <= 1'b0;
    end else begin
      r_pend <= i_cfg_update || (r_pend && !w_load);
      if (w_load) begin
        r_shift <= w_live_shift;
        r_round <= i_cfg_round;
        r_len   <= i_cfg_len;
      end
      if (w_accept) r_bin_cnt <= w_eop ? 16'd0 : r_bin_cnt + 16'd1;
      r_len_err <= w_accept && (s_if.last != w_at_last);
    end
  end

  for (genvar gi = 0; gi < NC; gi++) begin : g_comp
    logic signed [IN_W:0] w_x, w_y, r_y;
    logic                 w_hi, w_lo;

    assign w_x = {s_if.data[gi*IN_W + IN_W-1], s_if.data[gi*IN_W +: IN_W]};
    assign w_y = (w_x + $signed(w_rnd)) >>> w_shift;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_y <= '0;
      else if (w_accept) r_y <= w_y;
    end

    assign w_hi = (r_y > SAT_HI);
    assign w_lo = (r_y < SAT_LO);
    assign w_sat_vec[gi] = w_hi || w_lo;
    assign w_sat_data[gi*OUT_W +: OUT_W] = w_hi ? SAT_HI[OUT_W-1:0] :
                                           w_lo ? SAT_LO[OUT_W-1:0] : r_y[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sop   <= 1'b0;
      r_s1_eop   <= 1'b0;
      r_s1_bin   <= 16'd0;
    end else if (w_s1_en) begin
      r_s1_valid <= s_if.valid;
      if (s_if.valid) begin
        r_s1_sop <= (r_bin_cnt == 16'd0);
        r_s1_eop <= w_eop;
        r_s1_bin <= r_bin_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sop   <= 1'b0;
      r_s2_eop   <= 1'b0;
      r_s2_sat   <= 1'b0;
      r_s2_bin   <= 16'd0;
      r_s2_data  <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sop  <= r_s1_sop;
        r_s2_eop  <= r_s1_eop;
        r_s2_bin  <= r_s1_bin;
        r_s2_sat  <= |w_sat_vec;
        r_s2_data <= w_sat_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sat_cnt <= 32'd0;
    else if (i_sat_clr)
      r_sat_cnt <= 32'd0;
    else if (r_s2_valid && m_if.ready && r_s2_sat && (r_sat_cnt != 32'hFFFF_FFFF))
      r_sat_cnt <= r_sat_cnt + 32'd1;
  end

  assign m_if.valid = r_s2_valid;
  assign m_if.data  = r_s2_data;
  assign m_if.last  = r_s2_eop;
  assign m_if.sop   = r_s2_sop;
  assign m_if.bin   = r_s2_bin;
  assign o_sat_cnt  = r_sat_cnt;
  assign o_len_err  = r_len_err;
endmodule

// File: tb/tb_rfft_out_fmt.sv
// Directed/randomized bench for rfft_out_fmt with a frame-level reference model and scoreboard.
module tb_rfft_out_fmt;
  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int NCH   = 2;
  localparam int NC    = 2 * NCH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  cfg_shift = 5'd0;
  logic        cfg_round = 1'b0;
  logic [15:0] cfg_len = 16'd0;
  logic        cfg_update = 1'b0;
  logic        sat_clr = 1'b0;
  logic [31:0] sat_cnt;
  logic        len_err;

  always #5 clk = ~clk;

  rfft_out_fmt_if #(.DW(NC*IN_W))  s_bus ();
  rfft_out_fmt_if #(.DW(NC*OUT_W)) m_bus ();
  assign s_bus.sop = 1'b0;
  assign s_bus.bin = 16'd0;

  rfft_out_fmt #(.IN_W(IN_W), .OUT_W(OUT_W), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_shift(cfg_shift), .i_cfg_round(cfg_round), .i_cfg_len(cfg_len),
    .i_cfg_update(cfg_update),
    .s_if(s_bus), .m_if(m_bus),
    .i_sat_clr(sat_clr), .o_sat_cnt(sat_cnt), .o_len_err(len_err)
  );

  typedef struct packed {
    logic [NC*OUT_W-1:0] data;
    logic                sop;
    logic                eop;
    logic [15:0]         bin;
    logic                sat;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] obs_re_q[$];
  int          checks = 0;
  int          errors = 0;
  int          last_eop_bin = -1;
  bit          rand_ready = 1'b0;

  // Reference state: shadow config, pending flag, bin position, saturation count.
  int      md_shift = 8;
  bit      md_round = 1'b0;
  int      md_len   = 256;
  bit      md_pend  = 1'b0;
  int      md_bin   = 0;
  longint  md_sat   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Floor division by 2^sh with optional half-up bias, then clip to the output range.
  function automatic logic [15:0] fmt(input longint x, input int sh, input bit rd, output bit sat);
    longint d, num, q;
    d   = 64'sd1 <<< sh;
    num = x + ((rd && sh > 0) ? d / 2 : 64'sd0);
    q   = num / d;
    if ((num % d != 0) && (num < 0)) q = q - 1;
    sat = 1'b0;
    if (q > 32767) begin q = 32767; sat = 1'b1; end
    else if (q < -32768) begin q = -32768; sat = 1'b1; end
    return q[15:0];
  endfunction

  function automatic logic [NC*IN_W-1:0] mk(input logic [31:0] re0);
    logic [NC*IN_W-1:0] d;
    for (int c = 0; c < NC; c++) d[c*IN_W +: IN_W] = 32'($urandom_range(0, 32767)) - 32'd16384;
    d[31:0] = re0;
    return d;
  endfunction

  task automatic model_accept(input logic [NC*IN_W-1:0] d, input bit last, output bit exp_le);
    beat_t  e;
    bit     at_last, s;
    longint x;
    if (md_bin == 0 && md_pend) begin
      md_shift = (int'(cfg_shift) > IN_W-1) ? IN_W-1 : int'(cfg_shift);
      md_round = cfg_round;
      md_len   = (cfg_len == 16'd0) ? 65536 : int'(cfg_len);
      md_pend  = 1'b0;
    end
    at_last = (md_bin == md_len - 1);
    e.sop = (md_bin == 0);
    e.eop = at_last || last;
    e.bin = 16'(md_bin);
    e.sat = 1'b0;
    for (int c = 0; c < NC; c++) begin
      x = longint'($signed(d[c*IN_W +: IN_W]));
      e.data[c*OUT_W +: OUT_W] = fmt(x, md_shift, md_round, s);
      e.sat = e.sat | s;
    end
    exp_le = (last != at_last);
    md_bin = e.eop ? 0 : md_bin + 1;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [NC*IN_W-1:0] d, input bit last);
    bit done = 1'b0;
    bit exp_le = 1'b0;
    s_bus.valid = 1'b1;
    s_bus.data  = d;
    s_bus.last  = last;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (s_bus.ready) begin
        model_accept(d, last, exp_le);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    s_bus.valid = 1'b0;
    if (!done) chk("s_ready_timeout", 64'(s_bus.ready), 64'd1);
    else       chk("len_err", 64'(len_err), 64'(exp_le));
  endtask

  task automatic send_frame(input int n, input int last_at, input bit full, input logic [31:0] re0);
    logic [NC*IN_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = full ? {$urandom, $urandom, $urandom, $urandom} : mk(re0);
      send(d, i == last_at);
    end
  endtask

  task automatic cfg(input int sh, input bit rd, input int ln);
    cfg_shift  = 5'(sh);
    cfg_round  = rd;
    cfg_len    = 16'(ln);
    cfg_update = 1'b1;
    md_pend    = 1'b1;
    @(posedge clk); #1;
    cfg_update = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || m_bus.valid) && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_re(input string tag, input logic [15:0] exp);
    logic [15:0] o;
    o = 16'hDEAD;
    if (obs_re_q.size() != 0) o = obs_re_q.pop_front();
    chk(tag, 64'(o), 64'(exp));
  endtask

  // Output ready: always high, or a fair coin per cycle during stall tests.
  initial begin
    m_bus.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_bus.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop, stall stability and sat_cnt tracking.
  logic [NC*OUT_W-1:0] held_data;
  logic [17:0]         held_tag;
  bit                  stalled = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      stalled = 1'b0;
      md_sat  = 0;
    end else begin
      if (stalled) begin
        chk("stall_data", 64'(m_bus.data), 64'(held_data));
        chk("stall_tags", 64'({m_bus.sop, m_bus.last, m_bus.bin}), 64'(held_tag));
      end
      chk("sat_cnt", 64'(sat_cnt), 64'(md_sat));
      if (m_bus.valid && m_bus.ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_bus.valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", 64'(m_bus.data), 64'(e.data));
          chk("m_sop",  64'(m_bus.sop),  64'(e.sop));
          chk("m_eop",  64'(m_bus.last), 64'(e.eop));
          chk("m_bin",  64'(m_bus.bin),  64'(e.bin));
          obs_re_q.push_back(m_bus.data[15:0]);
          if (m_bus.last) last_eop_bin = int'(m_bus.bin);
          if (sat_clr) md_sat = 0;
          else if (e.sat && md_sat != 64'hFFFF_FFFF) md_sat = md_sat + 1;
        end
      end else if (sat_clr) begin
        md_sat = 0;
      end
      stalled   = m_bus.valid && !m_bus.ready;
      held_data = m_bus.data;
      held_tag  = {m_bus.sop, m_bus.last, m_bus.bin};
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    s_bus.valid = 1'b0;
    s_bus.data  = '0;
    s_bus.last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_bus.valid), 64'd0);
    chk("rst_m_data",  64'(m_bus.data),  64'd0);
    chk("rst_m_tags",  64'({m_bus.sop, m_bus.last, m_bus.bin}), 64'd0);
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Default config: 256-point frame, shift 8, first-beat latency
    send(mk(32'h0001_2380), 1'b0);
    chk("latency_t1", 64'(m_bus.valid), 64'd0);
    send(mk(32'h0001_2380), 1'b0);
    chk("latency_t2", 64'(m_bus.valid), 64'd1);
    send_frame(254, 253, 1'b0, 32'h0001_2380);
    drain();
    chk("t1_eop_bin", 64'(last_eop_bin), 64'd255);
    chk_re("t1_first_re", 16'h0123);
    obs_re_q.delete();

    // Rounding vs truncation at shift 4
    cfg(4, 1'b1, 3);
    send(mk(32'h0000_0018), 1'b0);
    send(mk(32'h0000_0017), 1'b0);
    send(mk(32'hFFFF_FFE8), 1'b1);
    cfg(4, 1'b0, 2);
    send(mk(32'h0000_0018), 1'b0);
    send(mk(32'h0000_0017), 1'b1);
    drain();
    chk_re("rnd_0x18", 16'h0002);
    chk_re("rnd_0x17", 16'h0001);
    chk_re("rnd_neg",  16'hFFFF);
    chk_re("trn_0x18", 16'h0001);
    chk_re("trn_0x17", 16'h0001);

    // Saturation at shift 0 and clear priority
    cfg(0, 1'b0, 2);
    send(mk(32'h0001_2345), 1'b0);
    send(mk(32'hFFFE_0000), 1'b1);
    drain();
    chk_re("sat_pos", 16'h7FFF);
    chk_re("sat_neg", 16'h8000);
    chk("sat_cnt_two", 64'(sat_cnt), 64'd2);
    sat_clr = 1'b1;
    send(mk(32'h0001_2345), 1'b0);
    send(mk(32'hFFFE_0000), 1'b1);
    drain();
    chk("sat_clr_prio", 64'(sat_cnt), 64'd0);
    sat_clr = 1'b0;
    obs_re_q.delete();

    // Random backpressure over three full-range frames
    cfg(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 64);
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(64, 63, 1'b1, 32'd0);
    drain();
    rand_ready = 1'b0;
    obs_re_q.delete();

    // Frame-length mismatches
    cfg(8, 1'b0, 64);
    send_frame(41, 40, 1'b0, 32'h0000_1000);
    drain();
    chk("early_last_eop", 64'(last_eop_bin), 64'd40);
    send_frame(64, -1, 1'b0, 32'h0000_1000);
    drain();
    chk("missing_last_eop", 64'(last_eop_bin), 64'd63);
    obs_re_q.delete();

    // Mid-frame cfg_update only takes effect at the next frame start
    cfg(8, 1'b0, 256);
    send_frame(10, -1, 1'b0, 32'h0001_2380);
    cfg(2, 1'b0, 128);
    send_frame(246, 245, 1'b0, 32'h0001_2380);
    drain();
    chk("old_frame_eop", 64'(last_eop_bin), 64'd255);
    chk_re("old_frame_re", 16'h0123);
    obs_re_q.delete();
    send_frame(128, 127, 1'b0, 32'h0000_0100);
    drain();
    chk("new_frame_eop", 64'(last_eop_bin), 64'd127);
    chk_re("new_frame_re", 16'h0040);
    obs_re_q.delete();

    // Asynchronous reset mid-frame, then restart with default shadow
    send_frame(20, -1, 1'b0, 32'h0000_0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 64'(m_bus.valid), 64'd0);
    chk("arst_m_data",  64'(m_bus.data),  64'd0);
    chk("arst_m_tags",  64'({m_bus.sop, m_bus.last, m_bus.bin}), 64'd0);
    exp_q.delete();
    obs_re_q.delete();
    md_bin = 0; md_pend = 1'b0; md_shift = 8; md_round = 1'b0; md_len = 256;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(5, -1, 1'b0, 32'h0001_2380);
    drain();
    chk_re("restart_re", 16'h0123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
